// File: rtl/atm_pkg.sv
// atm_pkg: state, operation and error encodings shared by the ATM session controller and its front-end.
package atm_pkg;
    typedef enum logic [2:0] {S_IDLE, S_LANG, S_PIN, S_OP, S_ANOTHER, S_EJECT} state_t;
    typedef enum logic [1:0] {OP_WITHDRAW, OP_DEPOSIT, OP_INQUIRY, OP_INVALID} op_t;
    localparam logic [2:0] ERR_NONE    = 3'd0;
    localparam logic [2:0] ERR_PIN     = 3'd1;
    localparam logic [2:0] ERR_FUNDS   = 3'd2;
    localparam logic [2:0] ERR_LIMIT   = 3'd3;
    localparam logic [2:0] ERR_OVF     = 3'd4;
    localparam logic [2:0] ERR_OP      = 3'd5;
    localparam logic [2:0] ERR_TIMEOUT = 3'd6;
endpackage

// File: rtl/atm_timeout_timer.sv
// atm_timeout_timer: inactivity down-counter; expired flags the last cycle of a TIMEOUT_CYC-cycle window.
module atm_timeout_timer #(
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic enable,
    output logic expired
);
    localparam int W = $clog2(TIMEOUT_CYC + 1);
    logic [W-1:0] cnt;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cnt <= '0;
        else if (load) cnt <= W'(TIMEOUT_CYC - 1);
        else if (enable && cnt != '0) cnt <= cnt - W'(1);
    end
    assign expired = enable && cnt == '0;
endmodule

// File: rtl/atm_session_ctrl.sv
// atm_session_ctrl: ATM session FSM with inactivity timeout, retry limits, withdrawal cap and
// a single balance write-back at eject when the session changed the balance.
module atm_session_ctrl
    import atm_pkg::*;
#(
    parameter int BAL_W       = 20,
    parameter int PIN_TRIES   = 3,
    parameter int OP_TRIES    = 3,
    parameter int TIMEOUT_CYC = 1024,
    parameter int WD_LIMIT    = 5000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             card_in,
    input  logic [BAL_W-1:0] acct_balance,
    input  logic             lang_valid,
    input  logic             language,
    input  logic             pin_valid,
    input  logic             pin_ok,
    input  logic             op_valid,
    input  logic [1:0]       operation,
    input  logic [BAL_W-1:0] value,
    input  logic             another_valid,
    input  logic             another_service,
    output logic [BAL_W-1:0] balance,
    output logic             lang_sel,
    output logic             op_done,
    output logic             error,
    output logic [2:0]       err_code,
    output logic             card_out,
    output logic             bal_we,
    output logic             busy
);
    localparam int PW = $clog2(PIN_TRIES + 1);
    localparam int OW = $clog2(OP_TRIES + 1);
    localparam logic [BAL_W+1:0] WD_LIM = (BAL_W+2)'(WD_LIMIT);

    state_t           state, state_n;
    logic [BAL_W-1:0] orig, orig_n, bal_n;
    logic [BAL_W:0]   wd_sum, wd_n, dep_sum;
    logic [BAL_W+1:0] wd_try;
    logic [PW-1:0]    pin_cnt, pin_n;
    logic [OW-1:0]    op_cnt, opc_n;
    logic [2:0]       code_n;
    logic             lang_n, done_n, err_n, strobe, charge, expired, tmr_en;

    assign dep_sum = {1'b0, balance} + {1'b0, value};
    assign wd_try  = {1'b0, wd_sum} + {2'b0, value};
    assign tmr_en  = state inside {S_LANG, S_PIN, S_OP, S_ANOTHER};

    atm_timeout_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timer (
        .clk    (clk),
        .rst    (rst),
        .load   (strobe || state_n != state),
        .enable (tmr_en),
        .expired(expired)
    );

    always_comb begin
        state_n = state;
        bal_n   = balance;
        orig_n  = orig;
        wd_n    = wd_sum;
        pin_n   = pin_cnt;
        opc_n   = op_cnt;
        lang_n  = lang_sel;
        code_n  = err_code;
        done_n  = 1'b0;
        err_n   = 1'b0;
        strobe  = 1'b0;
        charge  = 1'b0;
        case (state)
            S_IDLE: if (card_in) begin
                state_n = S_LANG;
                bal_n   = acct_balance;
                orig_n  = acct_balance;
                wd_n    = '0;
                pin_n   = '0;
                opc_n   = '0;
            end
            S_LANG: if (lang_valid) begin
                strobe  = 1'b1;
                lang_n  = language;
                state_n = S_PIN;
            end
            S_PIN: if (pin_valid) begin
                strobe = 1'b1;
                if (pin_ok) state_n = S_OP;
                else begin
                    err_n   = 1'b1;
                    code_n  = ERR_PIN;
                    pin_n   = pin_cnt + PW'(1);
                    state_n = pin_n == PW'(PIN_TRIES) ? S_EJECT : S_PIN;
                end
            end
            S_OP: if (op_valid) begin
                strobe = 1'b1;
                case (op_t'(operation))
                    OP_WITHDRAW:
                        if (value > balance) {err_n, charge, code_n} = {2'b11, ERR_FUNDS};
                        else if (wd_try > WD_LIM) {err_n, charge, code_n} = {2'b11, ERR_LIMIT};
                        else begin
                            bal_n  = balance - value;
                            wd_n   = wd_try[BAL_W:0];
                            done_n = 1'b1;
                        end
                    OP_DEPOSIT:
                        if (dep_sum[BAL_W]) {err_n, charge, code_n} = {2'b11, ERR_OVF};
                        else begin
                            bal_n  = dep_sum[BAL_W-1:0];
                            done_n = 1'b1;
                        end
                    OP_INQUIRY: done_n = 1'b1;
                    default: {err_n, code_n} = {1'b1, ERR_OP};
                endcase
                if (charge) opc_n = op_cnt + OW'(1);
                state_n = done_n ? S_ANOTHER : (charge && opc_n == OW'(OP_TRIES)) ? S_EJECT : S_OP;
            end
            S_ANOTHER: if (another_valid) begin
                strobe  = 1'b1;
                state_n = another_service ? S_OP : S_EJECT;
            end
            default: state_n = S_IDLE;
        endcase
        // a strobe landing in the expiry cycle has already been taken above
        if (expired && !strobe) begin
            err_n   = 1'b1;
            code_n  = ERR_TIMEOUT;
            state_n = S_EJECT;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_IDLE;
            balance  <= '0;
            orig     <= '0;
            wd_sum   <= '0;
            pin_cnt  <= '0;
            op_cnt   <= '0;
            lang_sel <= 1'b0;
            op_done  <= 1'b0;
            error    <= 1'b0;
            err_code <= ERR_NONE;
            card_out <= 1'b0;
            bal_we   <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state    <= state_n;
            balance  <= bal_n;
            orig     <= orig_n;
            wd_sum   <= wd_n;
            pin_cnt  <= pin_n;
            op_cnt   <= opc_n;
            lang_sel <= lang_n;
            op_done  <= done_n;
            error    <= err_n;
            err_code <= code_n;
            card_out <= state != S_EJECT && state_n == S_EJECT;
            bal_we   <= state != S_EJECT && state_n == S_EJECT && bal_n != orig;
            busy     <= state_n != S_IDLE;
        end
    end
endmodule

// File: tb/tb_atm_session_ctrl.sv
// tb_atm_session_ctrl: directed vector table plus hand sequences for timeout and mid-session reset.
module tb_atm_session_ctrl;
    localparam int TO = 32;
    localparam int K_NONE = 0, K_CARD = 1, K_LANG = 2, K_PIN = 3, K_OP = 4, K_ANO = 5;

    typedef struct {
        int          kind;
        logic [1:0]  sub;
        logic [19:0] val;
        logic [28:0] exp;
        string       name;
    } vec_t;

    logic        clk = 1'b0, rst = 1'b0;
    logic        card_in = 0, lang_valid = 0, language = 0, pin_valid = 0, pin_ok = 0;
    logic        op_valid = 0, another_valid = 0, another_service = 0;
    logic [1:0]  operation = 0;
    logic [19:0] acct_balance = 0, value = 0, balance;
    logic        lang_sel, op_done, error, card_out, bal_we, busy;
    logic [2:0]  err_code;
    int          passed = 0, total = 0;
    vec_t        tbl[$];

    atm_session_ctrl #(.TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst(rst), .card_in(card_in), .acct_balance(acct_balance),
        .lang_valid(lang_valid), .language(language), .pin_valid(pin_valid), .pin_ok(pin_ok),
        .op_valid(op_valid), .operation(operation), .value(value),
        .another_valid(another_valid), .another_service(another_service),
        .balance(balance), .lang_sel(lang_sel), .op_done(op_done), .error(error),
        .err_code(err_code), .card_out(card_out), .bal_we(bal_we), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    function automatic logic [28:0] e(input int bal, input bit lang, input bit done, input bit err,
                                      input int code, input bit co, input bit we, input bit bz);
        return {20'(bal), lang, done, err, 3'(code), co, we, bz};
    endfunction

    function automatic vec_t v(input string name, input int kind, input int sub, input int val,
                               input logic [28:0] exp);
        vec_t r;
        r.name = name; r.kind = kind; r.sub = 2'(sub); r.val = 20'(val); r.exp = exp;
        return r;
    endfunction

    function automatic string fmt(input logic [28:0] x);
        return $sformatf("bal=%0d lang=%b done=%b err=%b code=%0d out=%b we=%b busy=%b",
                         x[28:9], x[8], x[7], x[6], x[5:3], x[2], x[1], x[0]);
    endfunction

    task automatic check(input string name, input logic [28:0] exp);
        logic [28:0] act;
        act = {balance, lang_sel, op_done, error, err_code, card_out, bal_we, busy};
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %s, expected %s", name, fmt(act), fmt(exp));
    endtask

    task automatic step(input int kind, input int sub, input int val);
        card_in = kind == K_CARD; lang_valid = kind == K_LANG; pin_valid = kind == K_PIN;
        op_valid = kind == K_OP; another_valid = kind == K_ANO;
        acct_balance = 20'(val); value = 20'(val); operation = 2'(sub);
        language = sub[0]; pin_ok = sub[0]; another_service = sub[0];
        @(posedge clk);
        #1;
        {card_in, lang_valid, pin_valid, op_valid, another_valid} = '0;
    endtask

    initial begin
        tbl.push_back(v("idle_op_ignored", K_OP,   0, 5,       e(0,0,0,0,0,0,0,0)));
        tbl.push_back(v("t1_card",         K_CARD, 0, 1000,    e(1000,0,0,0,0,0,0,1)));
        tbl.push_back(v("t1_lang",         K_LANG, 0, 0,       e(1000,0,0,0,0,0,0,1)));
        tbl.push_back(v("t1_pin",          K_PIN,  1, 0,       e(1000,0,0,0,0,0,0,1)));
        tbl.push_back(v("t1_withdraw",     K_OP,   0, 300,     e(700,0,1,0,0,0,0,1)));
        tbl.push_back(v("t1_finish",       K_ANO,  0, 0,       e(700,0,0,0,0,1,1,1)));
        tbl.push_back(v("t1_idle",         K_NONE, 0, 0,       e(700,0,0,0,0,0,0,0)));
        tbl.push_back(v("t2_card",         K_CARD, 0, 500,     e(500,0,0,0,0,0,0,1)));
        tbl.push_back(v("t2_lang_ar",      K_LANG, 1, 0,       e(500,1,0,0,0,0,0,1)));
        tbl.push_back(v("t2_badpin1",      K_PIN,  0, 0,       e(500,1,0,1,1,0,0,1)));
        tbl.push_back(v("t2_gap",          K_NONE, 0, 0,       e(500,1,0,0,1,0,0,1)));
        tbl.push_back(v("t2_badpin2",      K_PIN,  0, 0,       e(500,1,0,1,1,0,0,1)));
        tbl.push_back(v("t2_badpin3",      K_PIN,  0, 0,       e(500,1,0,1,1,1,0,1)));
        tbl.push_back(v("t2_idle",         K_NONE, 0, 0,       e(500,1,0,0,1,0,0,0)));
        tbl.push_back(v("t3_card",         K_CARD, 0, 9000,    e(9000,1,0,0,1,0,0,1)));
        tbl.push_back(v("t3_card_busy",    K_CARD, 0, 123,     e(9000,1,0,0,1,0,0,1)));
        tbl.push_back(v("t3_lang",         K_LANG, 0, 0,       e(9000,0,0,0,1,0,0,1)));
        tbl.push_back(v("t3_pin",          K_PIN,  1, 0,       e(9000,0,0,0,1,0,0,1)));
        tbl.push_back(v("t3_wd4000",       K_OP,   0, 4000,    e(5000,0,1,0,1,0,0,1)));
        tbl.push_back(v("t3_continue",     K_ANO,  1, 0,       e(5000,0,0,0,1,0,0,1)));
        tbl.push_back(v("t3_wd2000_limit", K_OP,   0, 2000,    e(5000,0,0,1,3,0,0,1)));
        tbl.push_back(v("t3_wd1000",       K_OP,   0, 1000,    e(4000,0,1,0,3,0,0,1)));
        tbl.push_back(v("t3_finish",       K_ANO,  0, 0,       e(4000,0,0,0,3,1,1,1)));
        tbl.push_back(v("t3_idle",         K_NONE, 0, 0,       e(4000,0,0,0,3,0,0,0)));
        tbl.push_back(v("t4_card",         K_CARD, 0, 1048000, e(1048000,0,0,0,3,0,0,1)));
        tbl.push_back(v("t4_lang",         K_LANG, 0, 0,       e(1048000,0,0,0,3,0,0,1)));
        tbl.push_back(v("t4_pin",          K_PIN,  1, 0,       e(1048000,0,0,0,3,0,0,1)));
        tbl.push_back(v("t4_dep_ovf",      K_OP,   1, 1000,    e(1048000,0,0,1,4,0,0,1)));
        tbl.push_back(v("t4_inquiry",      K_OP,   2, 0,       e(1048000,0,1,0,4,0,0,1)));
        tbl.push_back(v("t4_continue",     K_ANO,  1, 0,       e(1048000,0,0,0,4,0,0,1)));
        tbl.push_back(v("t4_badop",        K_OP,   3, 0,       e(1048000,0,0,1,5,0,0,1)));
        tbl.push_back(v("t4_wd_funds",     K_OP,   0, 1048575, e(1048000,0,0,1,2,0,0,1)));
        tbl.push_back(v("t4_dep_ovf_ej",   K_OP,   1, 1048575, e(1048000,0,0,1,4,1,0,1)));
        tbl.push_back(v("t4_idle",         K_NONE, 0, 0,       e(1048000,0,0,0,4,0,0,0)));

        repeat (2) @(posedge clk);
        #1;
        check("reset_state", e(0,0,0,0,0,0,0,0));
        @(negedge clk);
        rst = 1'b1;
        foreach (tbl[i]) begin
            step(tbl[i].kind, int'(tbl[i].sub), int'(tbl[i].val));
            check(tbl[i].name, tbl[i].exp);
        end

        step(K_CARD, 0, 100); step(K_LANG, 0, 0); step(K_PIN, 1, 0);
        repeat (TO - 1) step(K_NONE, 0, 0);
        check("to_pre_expiry", e(100,0,0,0,4,0,0,1));
        step(K_NONE, 0, 0);
        check("to_expired", e(100,0,0,1,6,1,0,1));
        step(K_NONE, 0, 0);
        check("to_idle", e(100,0,0,0,6,0,0,0));

        step(K_CARD, 0, 200); step(K_LANG, 0, 0); step(K_PIN, 1, 0);
        repeat (TO - 1) step(K_NONE, 0, 0);
        step(K_OP, 2, 0);
        check("to_strobe_wins", e(200,0,1,0,6,0,0,1));
        step(K_ANO, 0, 0);
        check("to_win_finish", e(200,0,0,0,6,1,0,1));
        step(K_NONE, 0, 0);
        check("to_win_idle", e(200,0,0,0,6,0,0,0));

        step(K_CARD, 0, 1000); step(K_LANG, 1, 0); step(K_PIN, 1, 0);
        step(K_OP, 0, 100);
        check("rst_pre_dirty", e(900,1,1,0,6,0,0,1));
        #2 rst = 1'b0;
        #1 check("rst_async_clear", e(0,0,0,0,0,0,0,0));
        @(negedge clk);
        rst = 1'b1;
        step(K_ANO, 0, 0);
        check("rst_another_ignored", e(0,0,0,0,0,0,0,0));
        step(K_NONE, 0, 0);
        check("rst_no_eject", e(0,0,0,0,0,0,0,0));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
